rs232_mem_ctrl: RTL

Command controller that sits between the RS232 UART and the 16 KiB memory macro. It parses byte commands from the UART receiver and performs single-byte writes or reads on the memory port. It returns one response byte per command through the UART transmitter. This block is the initiator on the memory interface; the memory macro is the responder.

---
 rtl/rs232_mem_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rs232_mem_ctrl.sv
// -----------------------------------------------------------------------------
// rs232_mem_ctrl
//   Byte-command controller between the RS232 UART and the 16 KiB memory macro.
//   Commands:  'W' AH AL D -> write, reply 'K'
//              'R' AH AL   -> read,  reply stored byte
//              other       -> reply '?'
//   Address is {AH[5:0], AL}; AH[7:6] are ignored.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rx_data/rx_valid  byte strobe from UART receiver
//   tx_ready          UART transmitter can accept a byte
//   tx_data/tx_start  response byte and its one-cycle start pulse
//   mem_addr/mem_write/mem_data_in  memory request (initiator side)
//   mem_data_out      registered read data from the memory
//   busy              high whenever a command is in progress
//   rx_overrun        one-cycle pulse: a byte was dropped
// -----------------------------------------------------------------------------
module rs232_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [13:0] mem_addr,
    output logic        mem_write,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic        busy,
    output logic        rx_overrun
);

    localparam logic [19:0] TMO     = 20'(TIMEOUT_CYCLES);
    localparam logic [7:0]  CMD_W   = 8'h57;
    localparam logic [7:0]  CMD_R   = 8'h52;
    localparam logic [7:0]  RSP_OK  = 8'h4B;
    localparam logic [7:0]  RSP_BAD = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_WRITE,
        S_READ_REQ, S_READ_WAIT, S_SEND, S_SEND_WAIT
    } state_t;

    state_t      state_q;
    logic        is_write_q;
    logic        first_q;      // first SEND_WAIT cycle, tx_ready not yet trusted
    logic [19:0] tmo_q;
    logic [7:0]  tx_data_q;
    logic [13:0] mem_addr_q;
    logic [7:0]  mem_data_in_q;
    logic        mem_write_q;
    logic        rx_overrun_q;

    // States in which an incoming byte cannot be consumed.
    logic no_accept;
    assign no_accept = (state_q == S_WRITE)     || (state_q == S_READ_REQ) ||
                       (state_q == S_READ_WAIT) || (state_q == S_SEND)     ||
                       (state_q == S_SEND_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            is_write_q    <= 1'b0;
            first_q       <= 1'b0;
            tmo_q         <= '0;
            tx_data_q     <= '0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_write_q   <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            mem_write_q  <= 1'b0;
            rx_overrun_q <= rx_valid && no_accept;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_W || rx_data == CMD_R) begin
                            is_write_q <= (rx_data == CMD_W);
                            tmo_q      <= '0;
                            state_q    <= S_ADDR_H;
                        end else begin
                            tx_data_q <= RSP_BAD;
                            state_q   <= S_SEND;
                        end
                    end
                end
                // In the byte-collecting states an arriving byte wins over
                // a timeout firing in the same cycle.
                S_ADDR_H: begin
                    if (rx_valid) begin
                        mem_addr_q[13:8] <= rx_data[5:0];
                        tmo_q            <= '0;
                        state_q          <= S_ADDR_L;
                    end else if (tmo_q == TMO) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 20'd1;
                    end
                end
                S_ADDR_L: begin
                    if (rx_valid) begin
                        mem_addr_q[7:0] <= rx_data;
                        tmo_q           <= '0;
                        state_q         <= is_write_q ? S_DATA : S_READ_REQ;
                    end else if (tmo_q == TMO) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 20'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        mem_data_in_q <= rx_data;
                        mem_write_q   <= 1'b1;   // high exactly during WRITE
                        tmo_q         <= '0;
                        state_q       <= S_WRITE;
                    end else if (tmo_q == TMO) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 20'd1;
                    end
                end
                S_WRITE: begin
                    tx_data_q <= RSP_OK;
                    state_q   <= S_SEND;
                end
                // Address is already stable; memory samples it at the end
                // of this cycle and presents data during READ_WAIT.
                S_READ_REQ:  state_q <= S_READ_WAIT;
                S_READ_WAIT: begin
                    tx_data_q <= mem_data_out;
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        first_q <= 1'b1;
                        state_q <= S_SEND_WAIT;
                    end
                end
                S_SEND_WAIT: begin
                    first_q <= 1'b0;
                    if (!first_q && tx_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // tx_start is qualified by tx_ready in the same cycle so a start is never
    // issued to a transmitter that is not ready.
    assign tx_start    = (state_q == S_SEND) && tx_ready;
    assign busy        = (state_q != S_IDLE);
    assign tx_data     = tx_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_write   = mem_write_q;
    assign mem_data_in = mem_data_in_q;
    assign rx_overrun  = rx_overrun_q;

endmodule
